// File: rtl/cache_memory_responder.sv
`timescale 1ns/1ps
// cache_memory_responder
// Memory-side end of the cache<->memory block protocol. A block read or
// write-back request is latched, optionally delayed by WAIT_CYCLES, then
// serialised into BLOCK_SIZE word accesses on a single-port word RAM
// (1-cycle read latency). Completion is signalled by a one-cycle ack.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   mem_req    request: addr, cs, rw (0 read / 1 write), data[BLOCK_SIZE]
//   mem_resp   response: ack pulse, data[BLOCK_SIZE] (last read block)
//   ram_addr   word address to RAM (holds outside transfers)
//   ram_we     RAM write enable
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid the cycle after ram_addr

package cache_memory_responder_pkg;

  localparam int unsigned BLOCK_SIZE = 2;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned WORD_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]                 addr;
    logic                                  cs;
    logic                                  rw;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_request_t;

  typedef struct packed {
    logic                                  ack;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_response_t;

endpackage

module cache_memory_responder #(
  parameter int unsigned BLOCK_SIZE  = cache_memory_responder_pkg::BLOCK_SIZE,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_WIDTH  = cache_memory_responder_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH  = cache_memory_responder_pkg::WORD_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  cache_memory_responder_pkg::memory_request_t  mem_req,
  output cache_memory_responder_pkg::memory_response_t mem_resp,
  output logic [ADDR_WIDTH-1:0]                       ram_addr,
  output logic                                        ram_we,
  output logic [WORD_WIDTH-1:0]                       ram_wdata,
  input  logic [WORD_WIDTH-1:0]                       ram_rdata
);

  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int unsigned BEAT_WIDTH   = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;
  localparam int unsigned WAIT_WIDTH   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BLOCK_SIZE - 1);
  // Unreachable when WAIT_CYCLES == 0 (the WAIT state is never entered).
  localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_RDLAST,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t                  state, state_next;

  logic [ADDR_WIDTH-1:0]   base_q, base_n;
  logic                    rw_q, rw_n;
  block_t                  data_q, data_n;
  block_t                  rd_buf_q, rd_buf_n;
  logic [BEAT_WIDTH-1:0]   beat, beat_n;
  logic [WAIT_WIDTH-1:0]   wait_cnt, wait_n;
  logic [ADDR_WIDTH-1:0]   ram_addr_n;
  logic                    ram_we_n;
  logic [WORD_WIDTH-1:0]   ram_wdata_n;
  logic                    ack_q, ack_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (mem_req.cs) begin
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          state_next = S_XFER;
        end
      end
      S_XFER: begin
        if (beat == LAST_BEAT) begin
          state_next = rw_q ? S_ACK : S_RDLAST;
        end
      end
      S_RDLAST:  state_next = S_ACK;
      S_ACK:     state_next = S_RELEASE;
      // Wait for cs low so a request held across ack is not serviced twice.
      S_RELEASE: begin
        if (!mem_req.cs) begin
          state_next = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values; RAM controls are set up one cycle ahead
  // so the registered outputs line up with the beat they belong to.
  always_comb begin
    base_n      = base_q;
    rw_n        = rw_q;
    data_n      = data_q;
    rd_buf_n    = rd_buf_q;
    beat_n      = '0;
    wait_n      = '0;
    ram_addr_n  = ram_addr;
    ram_we_n    = 1'b0;
    ram_wdata_n = ram_wdata;
    ack_n       = (state_next == S_ACK);

    case (state)
      S_IDLE: begin
        if (mem_req.cs) begin
          base_n = mem_req.addr & BASE_MASK;
          rw_n   = mem_req.rw;
          data_n = mem_req.data;
          if (WAIT_CYCLES == 0) begin
            ram_addr_n  = base_n;
            ram_we_n    = mem_req.rw;
            ram_wdata_n = mem_req.data[0];
          end
        end
      end
      S_WAIT: begin
        wait_n = wait_cnt + 1'b1;
        if (wait_cnt == LAST_WAIT) begin
          ram_addr_n  = base_q;
          ram_we_n    = rw_q;
          ram_wdata_n = data_q[0];
        end
      end
      S_XFER: begin
        beat_n = beat + 1'b1;
        // Read data for the previous beat arrives this cycle.
        if (!rw_q && (beat != '0)) begin
          rd_buf_n[beat - 1'b1] = ram_rdata;
        end
        if (beat != LAST_BEAT) begin
          ram_addr_n  = base_q + ADDR_WIDTH'(beat_n);
          ram_we_n    = rw_q;
          ram_wdata_n = data_q[beat_n];
        end
      end
      S_RDLAST: begin
        rd_buf_n[BLOCK_SIZE-1] = ram_rdata;
      end
      default: begin
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      rw_q      <= 1'b0;
      data_q    <= '0;
      rd_buf_q  <= '0;
      beat      <= '0;
      wait_cnt  <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      ack_q     <= 1'b0;
    end else begin
      base_q    <= base_n;
      rw_q      <= rw_n;
      data_q    <= data_n;
      rd_buf_q  <= rd_buf_n;
      beat      <= beat_n;
      wait_cnt  <= wait_n;
      ram_addr  <= ram_addr_n;
      ram_we    <= ram_we_n;
      ram_wdata <= ram_wdata_n;
      ack_q     <= ack_n;
    end
  end

  // Response assembly
  always_comb begin
    mem_resp      = '0;
    mem_resp.ack  = ack_q;
    mem_resp.data = rd_buf_q;
  end

endmodule

// File: tb/tb_cache_memory_responder.sv
`timescale 1ns/1ps
module tb_cache_memory_responder;
  import cache_memory_responder_pkg::*;

  localparam int NCYC = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clear = 1'b1;
  memory_request_t  req;
  memory_response_t resp0, resp1;
  logic [15:0] ram_addr0, ram_addr1;
  logic        ram_we0, ram_we1;
  logic [31:0] ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

  logic [31:0] ram0 [0:4095];
  logic [31:0] ram1 [0:4095];
  logic [31:0] model_mem [0:4095];
  logic [63:0] exp_buf;

  int errors = 0;
  int checks = 0;

  logic        ack0_obs [0:NCYC];
  logic        ack1_obs [0:NCYC];
  logic        we0_obs  [0:NCYC];
  logic        we1_obs  [0:NCYC];
  logic [15:0] addr0_obs [0:NCYC];
  logic [15:0] addr1_obs [0:NCYC];
  logic [31:0] wd0_obs  [0:NCYC];
  logic [31:0] wd1_obs  [0:NCYC];
  logic [63:0] rd0_obs  [0:NCYC];
  logic [63:0] rd1_obs  [0:NCYC];

  always #5 clk = ~clk;

  cache_memory_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req(req), .mem_resp(resp0),
    .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  cache_memory_responder #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req), .mem_resp(resp1),
    .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  // Word RAMs with one-cycle read latency, one per responder
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 4096; i++) begin
        ram0[i] <= '0;
        ram1[i] <= '0;
      end
      ram_rdata0 <= '0;
      ram_rdata1 <= '0;
    end else begin
      if (ram_we0) ram0[ram_addr0[11:0]] <= ram_wdata0;
      if (ram_we1) ram1[ram_addr1[11:0]] <= ram_wdata1;
      ram_rdata0 <= ram0[ram_addr0[11:0]];
      ram_rdata1 <= ram1[ram_addr1[11:0]];
    end
  end

  task automatic snap(input int n);
    ack0_obs[n]  = resp0.ack;      ack1_obs[n]  = resp1.ack;
    we0_obs[n]   = ram_we0;        we1_obs[n]   = ram_we1;
    addr0_obs[n] = ram_addr0;      addr1_obs[n] = ram_addr1;
    wd0_obs[n]   = ram_wdata0;     wd1_obs[n]   = ram_wdata1;
    rd0_obs[n]   = resp0.data;     rd1_obs[n]   = resp1.data;
  endtask

  // Presents one request for NCYC cycles (cs optionally dropped at drop_at,
  // request fields scrambled at perturb_at), then idles cs for one cycle.
  task automatic drive_txn(input logic rw, input logic [15:0] addr,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int drop_at, input int perturb_at);
    snap(0);
    req.cs = 1'b1; req.rw = rw; req.addr = addr;
    req.data[0] = d0; req.data[1] = d1;
    for (int n = 1; n <= NCYC; n++) begin
      @(posedge clk); #1;
      snap(n);
      if (n == drop_at) req.cs = 1'b0;
      if (n == perturb_at) begin
        req.addr = 16'($urandom);
        req.data[0] = $urandom;
        req.data[1] = $urandom;
      end
    end
    req.cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (resp0.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", resp0.ack); end
    checks++; if (resp0.data !== 64'h0) begin errors++; $display("FAIL reset_data got %h expected 0", resp0.data); end
    checks++; if (ram_we0 !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", ram_we0); end
    checks++; if (ram_addr0 !== 16'h0) begin errors++; $display("FAIL reset_addr got %h expected 0", ram_addr0); end
    checks++; if (resp1.ack !== 1'b0 || ram_we1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got ack=%b we=%b expected 0/0", resp1.ack, ram_we1); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (resp0.ack !== 1'b0 || ram_we0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ack=%b we=%b expected 0/0", resp0.ack, ram_we0); end
  endtask

  task automatic test_write();
    logic [31:0] d0, d1;
    logic exp_we;
    d0 = 32'hAAAA0000; d1 = 32'hBBBB1111;
    drive_txn(1'b1, 16'h0013, d0, d1, 0, 0);
    for (int n = 1; n <= NCYC; n++) begin
      exp_we = (n == 1) || (n == 2);
      checks++; if (we0_obs[n] !== exp_we) begin errors++; $display("FAIL write_we n=%0d got %b expected %b", n, we0_obs[n], exp_we); end
      if (exp_we) begin
        checks++; if (addr0_obs[n] !== 16'h0012 + 16'(n - 1)) begin errors++; $display("FAIL write_addr n=%0d got %h expected %h", n, addr0_obs[n], 16'h0012 + 16'(n - 1)); end
        checks++; if (wd0_obs[n] !== ((n == 1) ? d0 : d1)) begin errors++; $display("FAIL write_data n=%0d got %h expected %h", n, wd0_obs[n], (n == 1) ? d0 : d1); end
      end
      checks++; if (ack0_obs[n] !== (n == 3)) begin errors++; $display("FAIL write_ack n=%0d got %b expected %b", n, ack0_obs[n], n == 3); end
    end
    model_mem[12'h012] = d0; model_mem[12'h013] = d1;
  endtask

  task automatic test_read();
    drive_txn(1'b0, 16'h0012, $urandom, $urandom, 0, 0);
    exp_buf = {model_mem[12'h013], model_mem[12'h012]};
    for (int n = 1; n <= NCYC; n++) begin
      checks++; if (we0_obs[n] !== 1'b0) begin errors++; $display("FAIL read_we n=%0d got %b expected 0", n, we0_obs[n]); end
      if (n <= 2) begin
        checks++; if (addr0_obs[n] !== 16'h0012 + 16'(n - 1)) begin errors++; $display("FAIL read_addr n=%0d got %h expected %h", n, addr0_obs[n], 16'h0012 + 16'(n - 1)); end
      end
      checks++; if (ack0_obs[n] !== (n == 4)) begin errors++; $display("FAIL read_ack n=%0d got %b expected %b", n, ack0_obs[n], n == 4); end
      if (n >= 4) begin
        checks++; if (rd0_obs[n] !== exp_buf) begin errors++; $display("FAIL read_data n=%0d got %h expected %h", n, rd0_obs[n], exp_buf); end
      end
    end
  endtask

  task automatic test_held_cs();
    logic [31:0] d0, d1;
    int acks0, acks1, wes0, wes1;
    d0 = $urandom; d1 = $urandom;
    acks0 = 0; acks1 = 0; wes0 = 0; wes1 = 0;
    drive_txn(1'b1, 16'h0031, d0, d1, 0, 0);
    for (int n = 1; n <= NCYC; n++) begin
      acks0 += int'(ack0_obs[n]); acks1 += int'(ack1_obs[n]);
      wes0  += int'(we0_obs[n]);  wes1  += int'(we1_obs[n]);
    end
    checks++; if (acks0 != 1) begin errors++; $display("FAIL held_acks0 got %0d expected 1", acks0); end
    checks++; if (wes0 != 2) begin errors++; $display("FAIL held_wes0 got %0d expected 2", wes0); end
    checks++; if (acks1 != 1) begin errors++; $display("FAIL held_acks1 got %0d expected 1", acks1); end
    checks++; if (wes1 != 2) begin errors++; $display("FAIL held_wes1 got %0d expected 2", wes1); end
    model_mem[12'h030] = d0; model_mem[12'h031] = d1;
    // cs was low for exactly one cycle; the next request must be taken at once
    drive_txn(1'b0, 16'h0030, $urandom, $urandom, 0, 0);
    exp_buf = {d1, d0};
    checks++; if (ack0_obs[4] !== 1'b1) begin errors++; $display("FAIL held_next_ack got %b expected 1", ack0_obs[4]); end
    checks++; if (rd0_obs[4] !== exp_buf) begin errors++; $display("FAIL held_next_data got %h expected %h", rd0_obs[4], exp_buf); end
  endtask

  task automatic test_wait_cycles();
    drive_txn(1'b0, 16'h0031, $urandom, $urandom, 0, 0);
    exp_buf = {model_mem[12'h031], model_mem[12'h030]};
    for (int n = 1; n <= NCYC; n++) begin
      checks++; if (we1_obs[n] !== 1'b0) begin errors++; $display("FAIL wait_we n=%0d got %b expected 0", n, we1_obs[n]); end
      if (n <= 3) begin
        checks++; if (addr1_obs[n] !== addr1_obs[0]) begin errors++; $display("FAIL wait_idle_addr n=%0d got %h expected %h", n, addr1_obs[n], addr1_obs[0]); end
      end else if (n <= 5) begin
        checks++; if (addr1_obs[n] !== 16'h0030 + 16'(n - 4)) begin errors++; $display("FAIL wait_addr n=%0d got %h expected %h", n, addr1_obs[n], 16'h0030 + 16'(n - 4)); end
      end
      checks++; if (ack1_obs[n] !== (n == 7)) begin errors++; $display("FAIL wait_ack n=%0d got %b expected %b", n, ack1_obs[n], n == 7); end
    end
    checks++; if (rd1_obs[7] !== exp_buf) begin errors++; $display("FAIL wait_data got %h expected %h", rd1_obs[7], exp_buf); end
    checks++; if (rd1_obs[NCYC] !== exp_buf) begin errors++; $display("FAIL wait_data_held got %h expected %h", rd1_obs[NCYC], exp_buf); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d0, d1;
    req.cs = 1'b1; req.rw = 1'b1; req.addr = 16'h0400;
    req.data[0] = $urandom; req.data[1] = $urandom;
    @(posedge clk); #1;
    checks++; if (ram_we0 !== 1'b1) begin errors++; $display("FAIL rstmid_beat0_we got %b expected 1", ram_we0); end
    rst = 1'b1;
    #1;
    checks++; if (ram_we0 !== 1'b0 || resp0.ack !== 1'b0) begin errors++; $display("FAIL rstmid_dut0 got we=%b ack=%b expected 0/0", ram_we0, resp0.ack); end
    checks++; if (ram_we1 !== 1'b0 || resp1.ack !== 1'b0) begin errors++; $display("FAIL rstmid_dut1 got we=%b ack=%b expected 0/0", ram_we1, resp1.ack); end
    checks++; if (ram_addr0 !== 16'h0 || resp0.data !== 64'h0) begin errors++; $display("FAIL rstmid_clear got addr=%h data=%h expected 0/0", ram_addr0, resp0.data); end
    exp_buf = '0;
    req.cs = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      checks++; if (resp0.ack !== 1'b0 || ram_we0 !== 1'b0) begin errors++; $display("FAIL rstmid_quiet n=%0d got ack=%b we=%b expected 0/0", n, resp0.ack, ram_we0); end
    end
    d0 = $urandom; d1 = $urandom;
    drive_txn(1'b1, 16'h0044, d0, d1, 0, 0);
    for (int n = 1; n <= NCYC; n++) begin
      checks++; if (ack0_obs[n] !== (n == 3)) begin errors++; $display("FAIL rstmid_next_ack n=%0d got %b expected %b", n, ack0_obs[n], n == 3); end
    end
    checks++; if (addr0_obs[1] !== 16'h0044 || wd0_obs[1] !== d0) begin errors++; $display("FAIL rstmid_next_beat0 got %h/%h expected 0044/%h", addr0_obs[1], wd0_obs[1], d0); end
    checks++; if (addr0_obs[2] !== 16'h0045 || wd0_obs[2] !== d1) begin errors++; $display("FAIL rstmid_next_beat1 got %h/%h expected 0045/%h", addr0_obs[2], wd0_obs[2], d1); end
    model_mem[12'h044] = d0; model_mem[12'h045] = d1;
  endtask

  task automatic test_request_change();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    drive_txn(1'b1, 16'h0051, d0, d1, 0, 1);
    checks++; if (we0_obs[2] !== 1'b1 || addr0_obs[2] !== 16'h0051 || wd0_obs[2] !== d1) begin errors++; $display("FAIL change_write_beat1 got we=%b %h/%h expected 1 0051/%h", we0_obs[2], addr0_obs[2], wd0_obs[2], d1); end
    checks++; if (ack0_obs[3] !== 1'b1) begin errors++; $display("FAIL change_write_ack got %b expected 1", ack0_obs[3]); end
    model_mem[12'h050] = d0; model_mem[12'h051] = d1;
    drive_txn(1'b0, 16'h0050, $urandom, $urandom, 2, 1);
    exp_buf = {d1, d0};
    for (int n = 1; n <= NCYC; n++) begin
      checks++; if (ack0_obs[n] !== (n == 4)) begin errors++; $display("FAIL change_read_ack n=%0d got %b expected %b", n, ack0_obs[n], n == 4); end
      checks++; if (ack1_obs[n] !== (n == 7)) begin errors++; $display("FAIL change_read_ack1 n=%0d got %b expected %b", n, ack1_obs[n], n == 7); end
    end
    checks++; if (addr0_obs[2] !== 16'h0051) begin errors++; $display("FAIL change_read_addr got %h expected 0051", addr0_obs[2]); end
    checks++; if (rd0_obs[4] !== exp_buf) begin errors++; $display("FAIL change_read_data got %h expected %h", rd0_obs[4], exp_buf); end
  endtask

  task automatic test_random();
    logic        rw, o_we, o_ack;
    logic [15:0] addr, base, o_addr;
    logic [31:0] d0, d1, o_wd;
    logic [63:0] new_buf, o_rd;
    int drop, pert, w, k, exp_ack;
    for (int t = 0; t < 24; t++) begin
      rw = 1'($urandom);
      addr = 16'($urandom_range(0, 255));
      base = {addr[15:1], 1'b0};
      d0 = $urandom; d1 = $urandom;
      drop = $urandom_range(0, 3);
      pert = $urandom_range(0, 3);
      new_buf = {model_mem[base[11:0] + 12'd1], model_mem[base[11:0]]};
      drive_txn(rw, addr, d0, d1, drop, pert);
      for (int d = 0; d < 2; d++) begin
        w = 3 * d;
        exp_ack = w + 3 + (rw ? 0 : 1);
        for (int n = 1; n <= NCYC; n++) begin
          o_we   = (d == 0) ? we0_obs[n]   : we1_obs[n];
          o_ack  = (d == 0) ? ack0_obs[n]  : ack1_obs[n];
          o_addr = (d == 0) ? addr0_obs[n] : addr1_obs[n];
          o_wd   = (d == 0) ? wd0_obs[n]   : wd1_obs[n];
          o_rd   = (d == 0) ? rd0_obs[n]   : rd1_obs[n];
          k = n - w - 1;
          checks++; if (o_we !== (rw && k >= 0 && k < 2)) begin errors++; $display("FAIL rand_we t=%0d dut%0d n=%0d got %b expected %b", t, d, n, o_we, rw && k >= 0 && k < 2); end
          if (k >= 0 && k < 2) begin
            checks++; if (o_addr !== base + 16'(k)) begin errors++; $display("FAIL rand_addr t=%0d dut%0d n=%0d got %h expected %h", t, d, n, o_addr, base + 16'(k)); end
            if (rw) begin
              checks++; if (o_wd !== ((k == 0) ? d0 : d1)) begin errors++; $display("FAIL rand_wdata t=%0d dut%0d n=%0d got %h expected %h", t, d, n, o_wd, (k == 0) ? d0 : d1); end
            end
          end
          checks++; if (o_ack !== (n == exp_ack)) begin errors++; $display("FAIL rand_ack t=%0d dut%0d n=%0d got %b expected %b", t, d, n, o_ack, n == exp_ack); end
          if (n >= exp_ack) begin
            checks++; if (o_rd !== (rw ? exp_buf : new_buf)) begin errors++; $display("FAIL rand_rdata t=%0d dut%0d n=%0d got %h expected %h", t, d, n, o_rd, rw ? exp_buf : new_buf); end
          end
        end
      end
      if (rw) begin
        model_mem[base[11:0]] = d0;
        model_mem[base[11:0] + 12'd1] = d1;
      end else begin
        exp_buf = new_buf;
      end
    end
  endtask

  initial begin
    req = '0;
    exp_buf = '0;
    for (int i = 0; i < 4096; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    ram_clear = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_held_cs();
    test_wait_cycles();
    test_reset_mid_write();
    test_request_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
